// File: rtl/calc_pkg.sv
// calc_pkg: key codes, FSM state encoding and helpers shared by the calculator
package calc_pkg;
   localparam logic [3:0] K_ADD = 4'd10;
   localparam logic [3:0] K_SUB = 4'd11;
   localparam logic [3:0] K_MUL = 4'd12;
   localparam logic [3:0] K_DIV = 4'd13;
   localparam logic [3:0] K_EQ  = 4'd14;
   localparam logic [3:0] K_CLR = 4'd15;
   localparam logic [2:0] ST_ENTER_A = 3'd0;
   localparam logic [2:0] ST_ENTER_B = 3'd1;
   localparam logic [2:0] ST_CALC    = 3'd2;
   localparam logic [2:0] ST_SHOW    = 3'd3;
   localparam logic [2:0] ST_ERROR   = 3'd4;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_e;
   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction
   function automatic op_e key2op(input logic [3:0] k);
      return op_e'(2'(k - K_ADD));
   endfunction
endpackage

// File: rtl/calc_if.sv
// calc_if: keypad strobe toward the engine, display and status back out
interface calc_if #(parameter int W = 14);
   logic         key_valid;
   logic [3:0]   key_code;
   logic [W-1:0] disp_value;
   logic         disp_neg;
   logic         err;
   logic         busy;
   logic         result_valid;
   modport master (output key_valid, key_code, input disp_value, disp_neg, err, busy, result_valid);
   modport slave  (input key_valid, key_code, output disp_value, disp_neg, err, busy, result_valid);
endinterface

// File: rtl/calc_muldiv.sv
// calc_muldiv: iterative unsigned shift-add multiply / restoring divide, one bit per cycle
module calc_muldiv #(parameter int W = 14) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           abort,
   input  logic           is_div,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] res
);
   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W);
   logic           run_q, run_d, div_q, div_d, step, ge;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   m_q, m_d, rem_q, rem_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W:0]     sum, rs;
   assign done = run_q && cnt_q == LAST;
   assign res  = acc_q;
   // mul: acc = {partial, multiplier}; div: acc[W-1:0] = dividend shifting into quotient
   always_comb begin
      step  = run_q && !done;
      sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
      rs    = {rem_q, acc_q[W-1]};
      ge    = rs >= {1'b0, m_q};
      run_d = abort ? 1'b0 : start ? 1'b1 : step;
      div_d = start ? is_div : div_q;
      m_d   = start ? (is_div ? b : a) : m_q;
      cnt_d = start ? '0 : step ? cnt_q + 1'b1 : cnt_q;
      rem_d = start ? '0 : (step && div_q) ? (ge ? W'(rs - {1'b0, m_q}) : rs[W-1:0]) : rem_q;
      acc_d = start ? {{W{1'b0}}, (is_div ? a : b)}
            : !step ? acc_q
            : div_q ? {{W{1'b0}}, acc_q[W-2:0], ge}
            : {sum, acc_q[W-1:1]};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q <= 1'b0;
         div_q <= 1'b0;
         cnt_q <= '0;
         m_q   <= '0;
         rem_q <= '0;
         acc_q <= '0;
      end else begin
         run_q <= run_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
         m_q   <= m_d;
         rem_q <= rem_d;
         acc_q <= acc_d;
      end
   end
endmodule

// File: rtl/calc_engine.sv
// calc_engine: keypad-driven sign-magnitude calculator FSM with chained operators
module calc_engine import calc_pkg::*; #(
   parameter int DIGITS = 4,
   parameter int W      = 14
) (
   input logic   clk,
   input logic   rst_n,
   calc_if.slave bus
);
   localparam int MAXV = pow10(DIGITS) - 1;
   localparam logic [W+3:0]   MAXV_E = (W+4)'(MAXV);
   localparam logic [2*W-1:0] MAXV_R = (2*W)'(MAXV);
   if ((64'd1 << W) <= 64'(MAXV)) begin : g_w_check
      $error("calc_engine: W too narrow for DIGITS");
   end
   logic [2:0]            state_q, state_d;
   logic [W-1:0]          a_q, a_d, b_q, b_d, disp_q, disp_d, acc_src;
   logic                  a_neg_q, a_neg_d, b_ent_q, b_ent_d, eq_q, eq_d;
   logic                  neg_q, neg_d, err_q, err_d, rv_q, rv_d;
   op_e                   op_q, op_d, nop_q, nop_d;
   logic                  kv_dig, kv_op, kv_eq, kv_clr, dig_ok, show_b;
   logic [W+3:0]          dig_new;
   logic signed [W+1:0]   sa, sb, as_sum;
   logic [W:0]            as_mag;
   logic [2*W-1:0]        r_mag, md_res;
   logic                  r_neg, r_err, md_op, calc_done, md_start, md_done;
   calc_muldiv #(.W(W)) u_md (
      .clk(clk), .rst_n(rst_n), .start(md_start), .abort(kv_clr), .is_div(op_q == OP_DIV),
      .a(a_q), .b(b_q), .done(md_done), .res(md_res)
   );
   always_comb begin
      kv_dig    = bus.key_valid && bus.key_code <= 4'd9;
      kv_op     = bus.key_valid && bus.key_code >= K_ADD && bus.key_code <= K_DIV;
      kv_eq     = bus.key_valid && bus.key_code == K_EQ;
      kv_clr    = bus.key_valid && bus.key_code == K_CLR;
      acc_src   = state_q == ST_ENTER_B ? b_q : state_q == ST_SHOW ? '0 : a_q;
      dig_new   = {1'b0, acc_src, 3'b0} + {3'b0, acc_src, 1'b0} + {{W{1'b0}}, bus.key_code};
      dig_ok    = dig_new <= MAXV_E;
      sa        = a_neg_q ? -$signed({2'b0, a_q}) : $signed({2'b0, a_q});
      sb        = $signed({2'b0, b_q});
      as_sum    = op_q == OP_SUB ? sa - sb : sa + sb;
      as_mag    = as_sum[W+1] ? (W+1)'(-as_sum) : as_sum[W:0];
      md_op     = op_q == OP_MUL || op_q == OP_DIV;
      r_mag     = op_q == OP_MUL ? md_res
                : op_q == OP_DIV ? {{W{1'b0}}, md_res[W-1:0]}
                : {{(W-1){1'b0}}, as_mag};
      r_neg     = (md_op ? a_neg_q : as_sum[W+1]) && r_mag != '0;
      r_err     = r_mag > MAXV_R || (op_q == OP_DIV && b_q == '0);
      calc_done = md_op ? md_done : 1'b1;
      state_d   = state_q;
      a_d       = a_q;
      a_neg_d   = a_neg_q;
      b_d       = b_q;
      b_ent_d   = b_ent_q;
      op_d      = op_q;
      nop_d     = nop_q;
      eq_d      = eq_q;
      rv_d      = 1'b0;
      md_start  = 1'b0;
      if (kv_clr) begin
         state_d = ST_ENTER_A;
         a_d     = '0;
         a_neg_d = 1'b0;
         b_d     = '0;
         b_ent_d = 1'b0;
         op_d    = OP_ADD;
         nop_d   = OP_ADD;
         eq_d    = 1'b0;
      end else begin
         case (state_q)
            ST_ENTER_A, ST_SHOW: begin
               if (kv_dig && dig_ok) begin
                  a_d     = dig_new[W-1:0];
                  a_neg_d = 1'b0;
                  state_d = ST_ENTER_A;
               end else if (kv_op) begin
                  op_d    = key2op(bus.key_code);
                  b_d     = '0;
                  b_ent_d = 1'b0;
                  state_d = ST_ENTER_B;
               end
            end
            ST_ENTER_B: begin
               if (kv_dig && dig_ok) begin
                  b_d     = dig_new[W-1:0];
                  b_ent_d = 1'b1;
               end else if (kv_op || kv_eq) begin
                  eq_d     = kv_eq;
                  nop_d    = key2op(bus.key_code);
                  md_start = md_op;
                  state_d  = ST_CALC;
               end
            end
            ST_CALC: begin
               if (calc_done) begin
                  rv_d = 1'b1;
                  if (r_err) state_d = ST_ERROR;
                  else begin
                     a_d     = r_mag[W-1:0];
                     a_neg_d = r_neg;
                     b_d     = '0;
                     b_ent_d = 1'b0;
                     op_d    = nop_q;
                     state_d = eq_q ? ST_SHOW : ST_ENTER_B;
                  end
               end
            end
            default: ;
         endcase
      end
      // B is shown only once its first digit arrives; otherwise A (entry or last result)
      show_b = state_d == ST_ENTER_B && b_ent_d;
      disp_d = state_d == ST_ERROR ? '0 : state_d == ST_CALC ? disp_q : show_b ? b_d : a_d;
      neg_d  = state_d == ST_ERROR ? 1'b0 : state_d == ST_CALC ? neg_q : !show_b && a_neg_d && a_d != '0;
      err_d  = state_d == ST_ERROR;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ENTER_A;
         a_q     <= '0;
         a_neg_q <= 1'b0;
         b_q     <= '0;
         b_ent_q <= 1'b0;
         op_q    <= OP_ADD;
         nop_q   <= OP_ADD;
         eq_q    <= 1'b0;
         disp_q  <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         a_neg_q <= a_neg_d;
         b_q     <= b_d;
         b_ent_q <= b_ent_d;
         op_q    <= op_d;
         nop_q   <= nop_d;
         eq_q    <= eq_d;
         disp_q  <= disp_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
         rv_q    <= rv_d;
      end
   end
   assign bus.disp_value   = disp_q;
   assign bus.disp_neg     = neg_q;
   assign bus.err          = err_q;
   assign bus.busy         = state_q == ST_CALC;
   assign bus.result_valid = rv_q;
endmodule
